picobello_mesh_fabric: RTL and testbench
========================================

// Module: picobello_mesh_fabric
// PURPOSE
// - Parametrised NxM mesh link fabric joining tile NoC ports; lifts point-to-point wiring out of the chip top.
// - Every inter-tile link carries NumChan independent valid/ready channels, each buffered by a LinkDepth FIFO.
// - Outputs toward mesh edges (tie-offs) are sunk: flits are accepted, dropped and counted, and a sticky error is raised.
// - Sits between tile instances (cluster, cheshire, mem) in the top; replaces the combinational gen_x/gen_y/gen_dir loops.
// PARAMETERS
// - NumX        4       mesh columns
// - NumY        4       mesh rows
// - NumChan     3       channels per link (req, rsp, wide)
// - FlitWidth   128     payload bits per channel; narrower channels are zero-padded by the tile
// - LinkDepth   2       FIFO entries per link channel; 0 = combinational pass-through
// - CntWidth    16      width of the drop counter
// - TieOffMask  derived NumX*NumY*4-bit mask, bit (x*NumY+y)*4+d set = port d of tile (x,y) is a mesh edge
// PORTS  (L = NumX*NumY*4*NumChan; index i = ((x*NumY+y)*4+d)*NumChan+c; d: North=0 East=1 South=2 West=3)
// - clk_i          in   1            clock
// - rst_i          in   1            asynchronous reset, active-high
// - tile_valid_i   in   L            flit offered by tile (x,y) on its port d, channel c
// - tile_ready_o   out  L            fabric accepts that flit
// - tile_data_i    in   L*FlitWidth  flit payload from tiles
// - tile_valid_o   out  L            flit delivered to tile (x,y) port d channel c
// - tile_ready_i   in   L            tile accepts delivered flit
// - tile_data_o    out  L*FlitWidth  flit payload to tiles
// - drop_clr_i     in   1            synchronous clear of drop_cnt_o and drop_err_o
// - drop_cnt_o     out  CntWidth     saturating count of flits sunk at tie-offs, all ports summed
// - drop_err_o     out  1            sticky flag: at least one flit sunk since reset/clear
// BEHAVIOUR
// - Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high. All state clears on rst_i assertion.
// - Reset values: all FIFOs are empty, tile_valid_o='0, drop_cnt_o=0, drop_err_o=0.
//   - tile_ready_o='1 on tie-off ports. On linked ports it follows FIFO not-full, so it is 1 after reset when LinkDepth>=1.
// - Connectivity:
//   - Non-tie-off output of tile (x,y) dir d feeds the input of neighbour (x',y') on opposite(d).
//   - Neighbours: North y+1, South y-1, East x+1, West x-1.
//   - Tie-off input side drives valid=0 and data='0, never X.
// - Link FIFO, LinkDepth=D>=1:
//   - Push on valid&&ready; ready = !full, with no fall-through on full.
//   - Pop on out_valid&&out_ready. Output is registered: a flit accepted in cycle t is visible earliest at t+1.
//   - Push and pop in the same cycle keep the count; allowed at any count below D.
//   - D=1 gives 50% throughput; D>=2 sustains 1 flit/cycle.
//   - Order is preserved per channel; channels are fully independent, with no cross-channel blocking.
// - LinkDepth=0: valid/data/ready are wired straight through, with zero latency.
// - Tie-off sink:
//   - ready=1 always. Each accepted flit increments the drop count by 1 (per-cycle sum over all tie-off ports).
//   - The counter saturates at 2^CntWidth-1 with no wrap-around.
//   - drop_err_o sets in the cycle after the first sunk flit and holds until drop_clr_i or reset.
//   - drop_clr_i has priority over increments in the same cycle: the result is 0, and that cycle's drops are lost.
// - Protocol rules (SVA in bench, not in RTL):
//   - Once tile_valid_i is high it stays high with stable data until ready.
//   - The fabric obeys the same rule on tile_valid_o/tile_data_o.
// - Reset mid-operation: in-flight flits are discarded. No output glitches to valid=1 while rst_i is high.
// STRUCTURE
// - picobello_mesh_pkg contains:
//   - route_dir_e (North..West) and opposite_dir().
//   - neighbor_x()/neighbor_y().
//   - link_idx(x,y,d,c).
//   - tie_off_mask(NumX,NumY) function, which generates the TieOffMask default.
// - Sub-module picobello_link_fifo (params Depth, Width): one instance per non-tie-off directed link per channel.
//   - It owns the D=0 bypass and the full/empty pointer logic.
// - The top-level body holds only generate loops, the tie-off sink and the saturating popcount-add drop counter.
// TESTING
// - Reset: hold rst_i 3 cycles with random valids.
//   -> all tile_valid_o=0, drop_cnt_o=0, linked tile_ready_o=1 one cycle after release.
// - Single hop, D=2: tile(0,0) East ch0 sends 0xA5 at t.
//   -> tile(1,0) West ch0 valid with 0xA5 at t+1; latency 0 with D=0.
// - Throughput/backpressure, D=2: stream 100 incrementing flits East, sink ready toggling 1-0.
//   -> in-order delivery with no loss. Sink ready=1 gives 1 flit/cycle; sink ready=0 makes ready_o drop after 2 accepted flits.
// - Channel independence: block ch2 (wide) sink, keep ch0/ch1 flowing on same link.
//   -> ch0/ch1 sustain full rate while ch2 stalls.
// - Tie-off: tile(0,0) West sends 5 flits, 2 of them in the same cycle as tile(3,3) North.
//   -> drop_cnt_o=7, drop_err_o=1. Clearing in the cycle of an 8th drop -> drop_cnt_o=0, drop_err_o=0.
// - Saturation, CntWidth=4: sink 20 flits -> drop_cnt_o=15 and held; assert rst_i mid-stream -> counter and FIFOs cleared.

Source files
------------

// File: rtl/picobello_mesh_fabric_pkg.sv
// rtl/picobello_mesh_fabric_pkg.sv - mesh geometry helpers shared by the fabric files
// Provides direction encoding, neighbour arithmetic, flat link indexing and
// the tie-off (mesh edge) mask generator. No ports.
package picobello_mesh_pkg;

  typedef enum logic [1:0] {
    North = 2'd0,
    East  = 2'd1,
    South = 2'd2,
    West  = 2'd3
  } route_dir_e;

  // Upper bound on NumX*NumY*4; covers meshes up to 16x16.
  localparam int MaxPorts = 1024;

  function automatic int opposite_dir(input int d);
    return (d + 2) % 4;
  endfunction

  function automatic int neighbor_x(input int x, input int d);
    if (d == int'(East)) return x + 1;
    if (d == int'(West)) return x - 1;
    return x;
  endfunction

  function automatic int neighbor_y(input int y, input int d);
    if (d == int'(North)) return y + 1;
    if (d == int'(South)) return y - 1;
    return y;
  endfunction

  function automatic int link_idx(input int x, input int y, input int d, input int c,
                                  input int num_y, input int num_chan);
    return ((x * num_y + y) * 4 + d) * num_chan + c;
  endfunction

  // Bit (x*num_y+y)*4+d is set when port d of tile (x,y) faces off the mesh.
  function automatic logic [MaxPorts-1:0] tie_off_mask(input int num_x, input int num_y);
    logic [MaxPorts-1:0] m;
    int nx;
    int ny;
    m = '0;
    for (int x = 0; x < num_x; x++) begin
      for (int y = 0; y < num_y; y++) begin
        for (int d = 0; d < 4; d++) begin
          nx = neighbor_x(x, d);
          ny = neighbor_y(y, d);
          if (nx < 0 || nx >= num_x || ny < 0 || ny >= num_y) m[(x * num_y + y) * 4 + d] = 1'b1;
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/picobello_mesh_fabric_if.sv
// rtl/picobello_mesh_fabric_if.sv - tile-facing handshake bundle of the mesh fabric
// Signals (L = NumX*NumY*4*NumChan, one bit/slice per tile port channel):
//   tile_valid_i/tile_data_i/tile_ready_o : flits offered by tiles into the fabric
//   tile_valid_o/tile_data_o/tile_ready_i : flits delivered by the fabric to tiles
// Modports: master = tile side, slave = fabric side.
interface picobello_mesh_fabric_if #(
  parameter int NumX      = 4,
  parameter int NumY      = 4,
  parameter int NumChan   = 3,
  parameter int FlitWidth = 128
);
  localparam int L = NumX * NumY * 4 * NumChan;

  logic [L-1:0]           tile_valid_i;
  logic [L-1:0]           tile_ready_o;
  logic [L*FlitWidth-1:0] tile_data_i;
  logic [L-1:0]           tile_valid_o;
  logic [L-1:0]           tile_ready_i;
  logic [L*FlitWidth-1:0] tile_data_o;

  modport master (
    output tile_valid_i, tile_data_i, tile_ready_i,
    input  tile_ready_o, tile_valid_o, tile_data_o
  );

  modport slave (
    input  tile_valid_i, tile_data_i, tile_ready_i,
    output tile_ready_o, tile_valid_o, tile_data_o
  );
endinterface

// File: rtl/picobello_mesh_fabric_link_fifo.sv
// rtl/picobello_mesh_fabric_link_fifo.sv - one directed link channel buffer
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data from the
// sending tile; out_valid/out_ready/out_data toward the receiving tile.
// Depth=0 is a wire; Depth>=1 is a circular buffer with registered output.
module picobello_link_fifo #(
  parameter int Depth = 2,
  parameter int Width = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  if (Depth == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
  end else begin : g_buf
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             push;
    logic             pop;

    // ready depends only on occupancy: a full buffer never accepts, even if
    // it is draining in the same cycle.
    assign in_ready  = (count != CntW'(Depth));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
        if (push && !pop) count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/picobello_mesh_fabric.sv
// rtl/picobello_mesh_fabric.sv - NxM mesh link fabric between tile NoC ports
// Ports: clk_i, rst_i (async, active-high); tile (slave side of the tile
// handshake bundle); drop_clr_i clears the drop statistics; drop_cnt_o is the
// saturating count of flits sunk at mesh edges; drop_err_o is its sticky flag.
module picobello_mesh_fabric
  import picobello_mesh_pkg::*;
#(
  parameter int NumX      = 4,
  parameter int NumY      = 4,
  parameter int NumChan   = 3,
  parameter int FlitWidth = 128,
  parameter int LinkDepth = 2,
  parameter int CntWidth  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  picobello_mesh_fabric_if.slave tile,
  input  logic                  drop_clr_i,
  output logic [CntWidth-1:0]   drop_cnt_o,
  output logic                  drop_err_o
);

  localparam int NumPorts = NumX * NumY * 4;
  localparam int L        = NumPorts * NumChan;
  localparam logic [MaxPorts-1:0] FullMask   = tie_off_mask(NumX, NumY);
  localparam logic [NumPorts-1:0] TieOffMask = FullMask[NumPorts-1:0];
  localparam int SumW = $clog2(L + 1);
  localparam int ExtW = ((CntWidth > SumW) ? CntWidth : SumW) + 1;
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [L-1:0] sink_valid;
  logic [L-1:0] unused_tie_bits;

  for (genvar x = 0; x < NumX; x++) begin : g_x
    for (genvar y = 0; y < NumY; y++) begin : g_y
      for (genvar d = 0; d < 4; d++) begin : g_d
        for (genvar c = 0; c < NumChan; c++) begin : g_c
          localparam int I = link_idx(x, y, d, c, NumY, NumChan);
          if (TieOffMask[(x * NumY + y) * 4 + d]) begin : g_tie
            // Edge port: swallow outgoing flits, present an idle input.
            assign tile.tile_ready_o[I]                      = 1'b1;
            assign tile.tile_valid_o[I]                      = 1'b0;
            assign tile.tile_data_o[I*FlitWidth +: FlitWidth] = '0;
            assign sink_valid[I]                             = tile.tile_valid_i[I];
            assign unused_tie_bits[I] = tile.tile_ready_i[I] ^ (^tile.tile_data_i[I*FlitWidth +: FlitWidth]);
          end else begin : g_link
            localparam int J = link_idx(neighbor_x(x, d), neighbor_y(y, d), opposite_dir(d), c,
                                        NumY, NumChan);
            assign sink_valid[I]      = 1'b0;
            assign unused_tie_bits[I] = 1'b0;
            picobello_link_fifo #(
              .Depth(LinkDepth),
              .Width(FlitWidth)
            ) u_fifo (
              .clk      (clk_i),
              .rst      (rst_i),
              .in_valid (tile.tile_valid_i[I]),
              .in_ready (tile.tile_ready_o[I]),
              .in_data  (tile.tile_data_i[I*FlitWidth +: FlitWidth]),
              .out_valid(tile.tile_valid_o[J]),
              .out_ready(tile.tile_ready_i[J]),
              .out_data (tile.tile_data_o[J*FlitWidth +: FlitWidth])
            );
          end
        end
      end
    end
  end

  // Several edge ports can sink in one cycle, so the counter adds a popcount.
  logic [SumW-1:0] drop_num;
  logic [ExtW-1:0] drop_sum;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < L; i++) drop_num = drop_num + SumW'(sink_valid[i]);
    drop_sum = ExtW'(drop_cnt_o) + ExtW'(drop_num);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
      drop_err_o <= 1'b0;
    end else if (drop_clr_i) begin
      drop_cnt_o <= '0;
      drop_err_o <= 1'b0;
    end else begin
      drop_cnt_o <= (drop_sum > ExtW'(CntMax)) ? CntMax : drop_sum[CntWidth-1:0];
      if (drop_num != '0) drop_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_picobello_mesh_fabric.sv
// tb/tb_picobello_mesh_fabric.sv - directed self-checking bench for picobello_mesh_fabric
module tb_picobello_mesh_fabric;

  localparam int NX = 4;
  localparam int NY = 4;
  localparam int NC = 3;
  localparam int W  = 16;
  localparam int L  = NX * NY * 4 * NC;

  // Hand-computed flat indices: ((x*4+y)*4+d)*3+c
  localparam int SRC0  = 3;    // tile(0,0) East  ch0
  localparam int DST0  = 57;   // tile(1,0) West  ch0
  localparam int TIE_W = 9;    // tile(0,0) West  ch0
  localparam int TIE_N = 180;  // tile(3,3) North ch0
  localparam int TIE_S = 6;    // tile(0,0) South ch0

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  picobello_mesh_fabric_if #(.NumX(NX), .NumY(NY), .NumChan(NC), .FlitWidth(W)) if_d2 (), if_d0 (), if_s ();

  logic        clr_d2, clr_d0, clr_s;
  logic [15:0] cnt_d2, cnt_d0;
  logic [3:0]  cnt_s;
  logic        err_d2, err_d0, err_s;

  picobello_mesh_fabric #(.NumX(NX), .NumY(NY), .NumChan(NC), .FlitWidth(W), .LinkDepth(2), .CntWidth(16)) u_d2 (
    .clk_i(clk), .rst_i(rst), .tile(if_d2), .drop_clr_i(clr_d2), .drop_cnt_o(cnt_d2), .drop_err_o(err_d2));
  picobello_mesh_fabric #(.NumX(NX), .NumY(NY), .NumChan(NC), .FlitWidth(W), .LinkDepth(0), .CntWidth(16)) u_d0 (
    .clk_i(clk), .rst_i(rst), .tile(if_d0), .drop_clr_i(clr_d0), .drop_cnt_o(cnt_d0), .drop_err_o(err_d0));
  picobello_mesh_fabric #(.NumX(NX), .NumY(NY), .NumChan(NC), .FlitWidth(W), .LinkDepth(1), .CntWidth(4)) u_s (
    .clk_i(clk), .rst_i(rst), .tile(if_s), .drop_clr_i(clr_s), .drop_cnt_o(cnt_s), .drop_err_o(err_s));

  // Delivered flits must hold valid and data until taken.
  for (genvar g = 0; g < L; g++) begin : g_proto
    assert property (@(posedge clk) disable iff (rst)
      (if_d2.tile_valid_o[g] && !if_d2.tile_ready_i[g]) |=>
      (if_d2.tile_valid_o[g] && $stable(if_d2.tile_data_o[g*W +: W])))
    else begin
      bad++;
      $error("FAIL proto_hold port=%0d", g);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_all();
    if_d2.tile_valid_i = '0; if_d2.tile_data_i = '0; if_d2.tile_ready_i = '1;
    if_d0.tile_valid_i = '0; if_d0.tile_data_i = '0; if_d0.tile_ready_i = '1;
    if_s.tile_valid_i  = '0; if_s.tile_data_i  = '0; if_s.tile_ready_i  = '1;
    clr_d2 = 1'b0; clr_d0 = 1'b0; clr_s = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < L; i++) begin
      if_d2.tile_valid_i[i] = 1'($urandom_range(0, 1));
      if_d2.tile_ready_i[i] = 1'($urandom_range(0, 1));
      if_d0.tile_valid_i[i] = 1'($urandom_range(0, 1));
      if_s.tile_valid_i[i]  = 1'($urandom_range(0, 1));
      if_s.tile_ready_i[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      #1;
      chk("rst_valid_d2", 256'(if_d2.tile_valid_o), 256'(0));
      chk("rst_valid_s", 256'(if_s.tile_valid_o), 256'(0));
      @(posedge clk); #1;
    end
    idle_all();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  int sent [3];
  int rcvd [3];
  int stall[3];
  int cyc;

  // Streams n flits per channel over the (0,0)->(1,0) link of the D=2 fabric.
  // Sink mode per channel: 0 always ready, 1 ready every other cycle, 2 never ready.
  task automatic run_link(input int n, input int m0, input int m1, input int m2);
    int   mode[3];
    logic acc [3];
    logic done;
    mode[0] = m0; mode[1] = m1; mode[2] = m2;
    for (int c = 0; c < 3; c++) begin sent[c] = 0; rcvd[c] = 0; stall[c] = 0; end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 1000) begin
      for (int c = 0; c < 3; c++) begin
        if_d2.tile_valid_i[SRC0+c]        = (sent[c] < n);
        if_d2.tile_data_i[(SRC0+c)*W +: W] = 16'(c * 256 + sent[c]);
        if_d2.tile_ready_i[DST0+c]        = (mode[c] == 0) || (mode[c] == 1 && (cyc % 2) == 0);
      end
      #1;
      for (int c = 0; c < 3; c++) begin
        acc[c] = if_d2.tile_valid_i[SRC0+c] && if_d2.tile_ready_o[SRC0+c];
        if (if_d2.tile_valid_i[SRC0+c] && !if_d2.tile_ready_o[SRC0+c]) stall[c]++;
        if (if_d2.tile_valid_o[DST0+c] && if_d2.tile_ready_i[DST0+c]) begin
          chk("link_order", 256'(if_d2.tile_data_o[(DST0+c)*W +: W]), 256'(c * 256 + rcvd[c]));
          rcvd[c]++;
        end
      end
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) if (acc[c]) sent[c]++;
      cyc++;
      done = 1'b1;
      for (int c = 0; c < 3; c++) if (mode[c] != 2 && rcvd[c] != n) done = 1'b0;
    end
    chk("link_budget", 256'(cyc < 1000), 256'(1));
    for (int c = 0; c < 3; c++) begin
      if_d2.tile_valid_i[SRC0+c] = 1'b0;
      if_d2.tile_ready_i[DST0+c] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    do_reset();
    chk("rst_valid_o_d2", 256'(if_d2.tile_valid_o), 256'(0));
    chk("rst_ready_o_d2", 256'(if_d2.tile_ready_o), {{(256-L){1'b0}}, {L{1'b1}}});
    chk("rst_ready_o_s", 256'(if_s.tile_ready_o), {{(256-L){1'b0}}, {L{1'b1}}});
    chk("rst_cnt_d2", 256'(cnt_d2), 256'(0));
    chk("rst_err_d2", 256'(err_d2), 256'(0));
    chk("rst_cnt_s", 256'(cnt_s), 256'(0));

    // Single hop through a two-deep link: visible one cycle after acceptance.
    if_d2.tile_valid_i[SRC0]        = 1'b1;
    if_d2.tile_data_i[SRC0*W +: W] = 16'h00A5;
    #1;
    chk("hop_d2_t0_valid", 256'(if_d2.tile_valid_o[DST0]), 256'(0));
    @(posedge clk); #1;
    if_d2.tile_valid_i[SRC0] = 1'b0;
    chk("hop_d2_t1_valid", 256'(if_d2.tile_valid_o[DST0]), 256'(1));
    chk("hop_d2_t1_data", 256'(if_d2.tile_data_o[DST0*W +: W]), 256'h00A5);
    @(posedge clk); #1;
    chk("hop_d2_drained", 256'(if_d2.tile_valid_o[DST0]), 256'(0));

    // Pass-through link: zero latency, ready mirrors the receiving tile.
    if_d0.tile_valid_i[SRC0]        = 1'b1;
    if_d0.tile_data_i[SRC0*W +: W] = 16'h00A5;
    #1;
    chk("hop_d0_valid", 256'(if_d0.tile_valid_o[DST0]), 256'(1));
    chk("hop_d0_data", 256'(if_d0.tile_data_o[DST0*W +: W]), 256'h00A5);
    chk("hop_d0_ready1", 256'(if_d0.tile_ready_o[SRC0]), 256'(1));
    if_d0.tile_ready_i[DST0] = 1'b0;
    #1;
    chk("hop_d0_ready0", 256'(if_d0.tile_ready_o[SRC0]), 256'(0));
    idle_all();
    @(posedge clk); #1;

    // Full rate on all three channels: 20 flits in 21 cycles, no stalls.
    run_link(20, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk("full_rcvd", 256'(rcvd[c]), 256'(20));
      chk("full_stall", 256'(stall[c]), 256'(0));
    end
    chk("full_cycles", 256'(cyc), 256'(21));

    // Wide channel blocked: others keep full rate, blocked one stops after 2.
    do_reset();
    run_link(30, 0, 0, 2);
    chk("ind_rcvd0", 256'(rcvd[0]), 256'(30));
    chk("ind_rcvd1", 256'(rcvd[1]), 256'(30));
    chk("ind_stall0", 256'(stall[0]), 256'(0));
    chk("ind_stall1", 256'(stall[1]), 256'(0));
    chk("ind_cycles", 256'(cyc), 256'(31));
    chk("ind_sent2", 256'(sent[2]), 256'(2));
    chk("ind_rcvd2", 256'(rcvd[2]), 256'(0));
    chk("ind_full_ready2", 256'(if_d2.tile_ready_o[SRC0+2]), 256'(0));
    chk("ind_held_valid2", 256'(if_d2.tile_valid_o[DST0+2]), 256'(1));
    rst = 1'b1;
    #1;
    chk("midrst_discard", 256'(if_d2.tile_valid_o[DST0+2]), 256'(0));
    do_reset();

    // Toggling sink: 100 flits per channel, in order, none lost.
    run_link(100, 1, 1, 1);
    for (int c = 0; c < 3; c++) chk("toggle_rcvd", 256'(rcvd[c]), 256'(100));

    // Edge sinks: 5 flits West of (0,0), 2 of them alongside North of (3,3).
    do_reset();
    if_d2.tile_valid_i[TIE_W] = 1'b1;
    if_d2.tile_ready_i[TIE_W] = 1'b0;
    #1;
    chk("tie_ready", 256'(if_d2.tile_ready_o[TIE_W]), 256'(1));
    chk("tie_valid_o", 256'(if_d2.tile_valid_o[TIE_W]), 256'(0));
    chk("tie_data_o", 256'(if_d2.tile_data_o[TIE_W*W +: W]), 256'(0));
    @(posedge clk); #1;
    chk("tie_cnt1", 256'(cnt_d2), 256'(1));
    chk("tie_err1", 256'(err_d2), 256'(1));
    for (int k = 1; k < 5; k++) begin
      if_d2.tile_valid_i[TIE_N] = (k >= 3);
      @(posedge clk); #1;
    end
    if_d2.tile_valid_i[TIE_W] = 1'b0;
    if_d2.tile_valid_i[TIE_N] = 1'b0;
    chk("tie_cnt7", 256'(cnt_d2), 256'(7));
    chk("tie_err7", 256'(err_d2), 256'(1));
    @(posedge clk); #1;
    chk("tie_cnt7_hold", 256'(cnt_d2), 256'(7));
    if_d2.tile_valid_i[TIE_N] = 1'b1;
    clr_d2 = 1'b1;
    @(posedge clk); #1;
    if_d2.tile_valid_i[TIE_N] = 1'b0;
    clr_d2 = 1'b0;
    chk("clr_cnt", 256'(cnt_d2), 256'(0));
    chk("clr_err", 256'(err_d2), 256'(0));
    @(posedge clk); #1;
    chk("clr_err_hold", 256'(err_d2), 256'(0));

    // 4-bit counter saturates; single-entry link fills and back-pressures.
    do_reset();
    if_s.tile_valid_i[TIE_S]       = 1'b1;
    if_s.tile_valid_i[SRC0]        = 1'b1;
    if_s.tile_data_i[SRC0*W +: W] = 16'h0077;
    if_s.tile_ready_i[DST0]        = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
    end
    chk("sat_cnt", 256'(cnt_s), 256'(15));
    chk("sat_err", 256'(err_s), 256'(1));
    chk("d1_valid", 256'(if_s.tile_valid_o[DST0]), 256'(1));
    chk("d1_data", 256'(if_s.tile_data_o[DST0*W +: W]), 256'h0077);
    chk("d1_full", 256'(if_s.tile_ready_o[SRC0]), 256'(0));
    rst = 1'b1;
    #1;
    chk("sat_rst_cnt", 256'(cnt_s), 256'(0));
    chk("sat_rst_err", 256'(err_s), 256'(0));
    chk("sat_rst_valid", 256'(if_s.tile_valid_o[DST0]), 256'(0));
    chk("sat_rst_ready", 256'(if_s.tile_ready_o[SRC0]), 256'(1));
    @(posedge clk); #1;
    chk("sat_rst_hold_cnt", 256'(cnt_s), 256'(0));
    chk("sat_rst_hold_valid", 256'(if_s.tile_valid_o), 256'(0));
    idle_all();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("sat_post_cnt", 256'(cnt_s), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
